// File: rtl/actuator_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : actuator_sequencer_if                                  |
// | Description : Request/acknowledge inputs and actuator drive outputs  |
// |               of the cabin actuator sequencer.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface actuator_sequencer_if;
  logic       alarm_req_i;
  logic       elect_req_i;
  logic       ack_i;
  logic       buzzer_o;
  logic       window_open_o;
  logic       window_close_o;
  logic       fan_o;
  logic       escalate_o;
  logic [2:0] state_o;

  // Alarm FSM / user side: drives requests, observes actuators
  modport master (
    output alarm_req_i, elect_req_i, ack_i,
    input  buzzer_o, window_open_o, window_close_o, fan_o, escalate_o, state_o
  );

  // Sequencer side
  modport slave (
    input  alarm_req_i, elect_req_i, ack_i,
    output buzzer_o, window_open_o, window_close_o, fan_o, escalate_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/actuator_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : actuator_sequencer                                     |
// | Description : Buzzer cadence, alarm escalation, window motor stroke  |
// |               timing and fan control driven by the alarm FSM.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module actuator_sequencer #(
  parameter int TICK_DIV        = 50000,
  parameter int BEEP_ON_TICKS   = 4,
  parameter int BEEP_OFF_TICKS  = 4,
  parameter int WIN_MOTOR_TICKS = 20,
  parameter int ESC_TICKS       = 60,
  parameter int CNT_W           = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  actuator_sequencer_if.slave  bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ALERT = 3'd1;
  localparam logic [2:0] c_OPEN  = 3'd2;
  localparam logic [2:0] c_VENT  = 3'd3;
  localparam logic [2:0] c_CLOSE = 3'd4;

  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_BEEP_ON    = CNT_W'(BEEP_ON_TICKS);
  localparam logic [CNT_W-1:0] c_BEEP_OFF   = CNT_W'(BEEP_OFF_TICKS);
  localparam logic [CNT_W-1:0] c_MOTOR_LAST = CNT_W'(WIN_MOTOR_TICKS - 1);
  localparam logic [CNT_W-1:0] c_ESC        = CNT_W'(ESC_TICKS);
  localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_presc, w_presc_nxt;
  logic [CNT_W-1:0] r_cad_cnt, w_cad_cnt_nxt;
  logic             r_cad_off, w_cad_off_nxt;
  logic [CNT_W-1:0] r_motor_cnt, w_motor_cnt_nxt;
  logic [CNT_W-1:0] r_esc_cnt, w_esc_cnt_nxt;
  logic             r_escalate, w_escalate_nxt;
  logic             r_mute, w_mute_nxt;
  logic             r_buzzer, w_buzzer_nxt;
  logic             r_win_open, w_win_open_nxt;
  logic             r_win_close, w_win_close_nxt;
  logic             r_fan, w_fan_nxt;

  logic w_tick;
  logic w_motor_done;
  logic w_act_cur;
  logic w_act_nxt;
  logic w_to_idle;
  logic w_ack_act;
  logic [CNT_W-1:0] w_phase_len;

  assign w_tick       = (r_presc == c_TICK_LAST);
  // Stroke ends on the tick that completes the last motor tick
  assign w_motor_done = w_tick && (r_motor_cnt >= c_MOTOR_LAST);
  assign w_act_cur    = (r_state == c_ALERT) || (r_state == c_OPEN) || (r_state == c_VENT);
  assign w_act_nxt    = (w_state_nxt == c_ALERT) || (w_state_nxt == c_OPEN) ||
                        (w_state_nxt == c_VENT);
  assign w_to_idle    = (w_state_nxt == c_IDLE);
  assign w_ack_act    = bus.ack_i && w_act_cur;
  assign w_phase_len  = r_cad_off ? c_BEEP_OFF : c_BEEP_ON;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a dropped alarm request overrides every other condition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.alarm_req_i) w_state_nxt = c_ALERT;
      c_ALERT: begin
        if (!bus.alarm_req_i)     w_state_nxt = c_IDLE;
        else if (bus.elect_req_i) w_state_nxt = c_OPEN;
      end
      c_OPEN: begin
        if (!bus.alarm_req_i) w_state_nxt = c_CLOSE;
        else if (w_motor_done) w_state_nxt = c_VENT;
      end
      c_VENT:  if (!bus.alarm_req_i) w_state_nxt = c_CLOSE;
      c_CLOSE: if (w_motor_done) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Next values of the prescaler, cadence, motor and escalation bookkeeping
  always_comb begin
    // Prescaler restarts on every state change so strokes are cycle-exact
    if (w_state_nxt != r_state || w_tick) w_presc_nxt = '0;
    else                                  w_presc_nxt = r_presc + c_ONE;

    // Cadence runs only while staying within the alerting states
    w_cad_cnt_nxt = r_cad_cnt;
    w_cad_off_nxt = r_cad_off;
    if (!(w_act_cur && w_act_nxt)) begin
      w_cad_cnt_nxt = '0;
      w_cad_off_nxt = 1'b0;
    end else if (w_tick) begin
      if (r_cad_cnt + c_ONE >= w_phase_len) begin
        w_cad_cnt_nxt = '0;
        w_cad_off_nxt = ~r_cad_off;
      end else begin
        w_cad_cnt_nxt = r_cad_cnt + c_ONE;
      end
    end

    // Motor counter measures the current stroke only
    w_motor_cnt_nxt = r_motor_cnt;
    if (w_state_nxt != r_state) begin
      w_motor_cnt_nxt = '0;
    end else if ((r_state == c_OPEN || r_state == c_CLOSE) && w_tick &&
                 r_motor_cnt != c_CNT_MAX) begin
      w_motor_cnt_nxt = r_motor_cnt + c_ONE;
    end

    // Acknowledge beats a simultaneous escalation threshold
    w_esc_cnt_nxt  = r_esc_cnt;
    w_escalate_nxt = r_escalate;
    w_mute_nxt     = r_mute;
    if (w_to_idle) begin
      w_esc_cnt_nxt  = '0;
      w_escalate_nxt = 1'b0;
      w_mute_nxt     = 1'b0;
    end else if (w_ack_act) begin
      w_esc_cnt_nxt  = '0;
      w_escalate_nxt = 1'b0;
      w_mute_nxt     = 1'b1;
    end else if (w_act_cur && !r_mute) begin
      if (w_tick && r_esc_cnt < c_ESC) w_esc_cnt_nxt = r_esc_cnt + c_ONE;
      if (w_esc_cnt_nxt >= c_ESC)      w_escalate_nxt = 1'b1;
    end
  end

  // Actuator drives follow the state being entered so they change with state_o
  always_comb begin
    w_win_open_nxt  = (w_state_nxt == c_OPEN);
    w_win_close_nxt = (w_state_nxt == c_CLOSE);
    w_fan_nxt       = (w_state_nxt == c_OPEN) || (w_state_nxt == c_VENT);
    w_buzzer_nxt    = w_act_nxt && !w_mute_nxt && (w_escalate_nxt || !w_cad_off_nxt);
  end

  // Datapath and output registers; reset stops the motor immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_presc     <= '0;
      r_cad_cnt   <= '0;
      r_cad_off   <= 1'b0;
      r_motor_cnt <= '0;
      r_esc_cnt   <= '0;
      r_escalate  <= 1'b0;
      r_mute      <= 1'b0;
      r_buzzer    <= 1'b0;
      r_win_open  <= 1'b0;
      r_win_close <= 1'b0;
      r_fan       <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_cad_cnt   <= w_cad_cnt_nxt;
      r_cad_off   <= w_cad_off_nxt;
      r_motor_cnt <= w_motor_cnt_nxt;
      r_esc_cnt   <= w_esc_cnt_nxt;
      r_escalate  <= w_escalate_nxt;
      r_mute      <= w_mute_nxt;
      r_buzzer    <= w_buzzer_nxt;
      r_win_open  <= w_win_open_nxt;
      r_win_close <= w_win_close_nxt;
      r_fan       <= w_fan_nxt;
    end
  end

  assign bus.buzzer_o       = r_buzzer;
  assign bus.window_open_o  = r_win_open;
  assign bus.window_close_o = r_win_close;
  assign bus.fan_o          = r_fan;
  assign bus.escalate_o     = r_escalate;
  assign bus.state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_actuator_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_actuator_sequencer                                  |
// | Description : Directed plus random stimulus against a cycle-counting |
// |               behavioural model of the actuator sequencer.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_actuator_sequencer;
  localparam int TD  = 4;
  localparam int ON  = 2;
  localparam int OFF = 2;
  localparam int WM  = 3;
  localparam int ESC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  actuator_sequencer_if bus ();

  actuator_sequencer #(
    .TICK_DIV(TD), .BEEP_ON_TICKS(ON), .BEEP_OFF_TICKS(OFF),
    .WIN_MOTOR_TICKS(WM), .ESC_TICKS(ESC), .CNT_W(16)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state, cycles spent in it, ticks of cadence since alert began
  int m_s, m_t, m_cad, m_esc;
  bit m_mute, m_escal;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_act(input int s);
    return (s == 1) || (s == 2) || (s == 3);
  endfunction

  task automatic model_reset();
    m_s = 0; m_t = 0; m_cad = 0; m_esc = 0; m_mute = 0; m_escal = 0;
  endtask

  task automatic model_step(input bit a, input bit e, input bit k);
    int  ns;
    bit  tick;
    tick = (m_t % TD) == TD - 1;
    ns = m_s;
    case (m_s)
      0: if (a) ns = 1;
      1: if (!a) ns = 0; else if (e) ns = 2;
      2: if (!a) ns = 4; else if (m_t + 1 == WM * TD) ns = 3;
      3: if (!a) ns = 4;
      4: if (m_t + 1 == WM * TD) ns = 0;
      default: ns = 0;
    endcase
    if (is_act(m_s) && is_act(ns)) begin
      if (tick) m_cad++;
    end else begin
      m_cad = 0;
    end
    if (ns == 0) begin
      m_esc = 0; m_mute = 0; m_escal = 0;
    end else if (k && is_act(m_s)) begin
      m_esc = 0; m_mute = 1; m_escal = 0;
    end else if (is_act(m_s) && !m_mute) begin
      if (tick && m_esc < ESC) m_esc++;
      if (m_esc >= ESC) m_escal = 1;
    end
    m_t = (ns != m_s) ? 0 : m_t + 1;
    m_s = ns;
  endtask

  task automatic compare_all();
    bit buz;
    buz = is_act(m_s) && !m_mute && (m_escal || ((m_cad % (ON + OFF)) < ON));
    check_value("state",    int'(bus.state_o),        m_s);
    check_value("buzzer",   int'(bus.buzzer_o),       int'(buz));
    check_value("win_open", int'(bus.window_open_o),  int'(m_s == 2));
    check_value("win_close",int'(bus.window_close_o), int'(m_s == 4));
    check_value("fan",      int'(bus.fan_o),          int'(m_s == 2 || m_s == 3));
    check_value("escalate", int'(bus.escalate_o),     int'(m_escal));
    check_value("excl", int'(bus.window_open_o & bus.window_close_o), 0);
  endtask

  task automatic check_zero(input string tag);
    check_value({tag, "_state"}, int'(bus.state_o), 0);
    check_value({tag, "_outs"}, int'({bus.buzzer_o, bus.window_open_o, bus.window_close_o,
                                      bus.fan_o, bus.escalate_o}), 0);
  endtask

  task automatic step(input bit a, input bit e, input bit k);
    bus.alarm_req_i = a;
    bus.elect_req_i = e;
    bus.ack_i       = k;
    @(posedge clk);
    model_step(a, e, k);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input bit a, input bit e, input bit k);
    for (int i = 0; i < n; i++) step(a, e, k);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    bit a, e, k;
    bus.alarm_req_i = 1'b0;
    bus.elect_req_i = 1'b0;
    bus.ack_i       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Alert cadence and escalation, then acknowledge and hold muted
    run(60, 1, 0, 0);
    run(1, 1, 0, 1);
    run(20, 1, 0, 0);
    run(4, 0, 0, 0);
    // Full open stroke, ventilation, elect falling, close stroke
    run(5, 1, 0, 0);
    run(30, 1, 1, 0);
    run(10, 1, 0, 0);
    run(20, 0, 0, 0);
    // Abort the open stroke, then reset in the middle of closing
    run(2, 1, 0, 0);
    run(6, 1, 1, 0);
    run(5, 0, 0, 0);
    async_reset();
    run(3, 0, 0, 0);

    // Randomized request/ack traffic with occasional resets
    a = 0; e = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) a = ~a;
      if ($urandom_range(0, 24) == 0) e = ~e;
      k = ($urandom_range(0, 79) == 0);
      step(a, e, k);
      if ($urandom_range(0, 699) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
